spigot_e_sequencer: RTL and testbench
=====================================

# spigot_e_sequencer

Controller that runs the spigot algorithm for the digits of e over an external remainder RAM and a shared iterative divider. It initialises the mixed-radix remainder array, sequences the per-digit pass from the highest term down to term 0, and streams decimal digits ("2" first) through a valid/ready handshake. It sits between the top-level pin wrapper (start/digit output) and the remainder storage.

## Interface
- `N_TERMS`, 32: remainder array length; term i has radix i+2.
- `ADDR_W`, 5: RAM address width; must satisfy 2^ADDR_W ≥ N_TERMS.
- `DATA_W`, 8: remainder width; must hold N_TERMS+1.
- `MAX_DIGITS`, 32: digits emitted per run, including the leading 2.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins a run from IDLE or DONE.
- `busy` out 1: high from accepted start until the last digit handshake.
- `done` out 1: high in DONE until the next accepted start.
- `digit` out 4: BCD digit, 0..9.
- `digit_valid` out 1: digit present.
- `digit_ready` in 1: consumer accepts when valid && ready.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_we` out 1: RAM write enable.
- `mem_rdata` in DATA_W: RAM read data, valid the cycle after the address is presented (1-cycle synchronous read).

## Operation
- Algorithm per digit: carry=0; for i=N_TERMS-1 down to 0: x=mem[i]*10+carry; mem[i]=x mod (i+2); carry=x div (i+2); emit carry.
- Width rules: x is DATA_W+4 bits; carry and quotient are 4 bits, always ≤ 9 since mem[i] < i+2 and carry-in ≤ 9; no saturation.
- States:
  - IDLE: start → INIT.
  - INIT: write 1 to addresses 0..N_TERMS-1, one per cycle → EMIT2.
  - EMIT2: present digit 2 → PASS_START on handshake.
  - PASS_START: i=N_TERMS-1, carry=0 → RD.
  - RD: drive mem_addr=i → WT.
  - WT: capture mem_rdata; form x → DIV.
  - DIV: hold the divider busy → WR on div_done.
  - WR: write remainder to mem[i]; carry=quotient; if i==0 → OUT, else i-- → RD.
  - OUT: present carry as digit; on handshake increment the digit count; count==MAX_DIGITS → DONE, else → PASS_START.
  - DONE: start → INIT.
- start is ignored in every state except IDLE and DONE.
- digit is held stable while valid && !ready; valid never drops without a handshake.
- Reset (including mid-pass) returns to IDLE.
  - All outputs 0: digit, digit_valid, busy, done, mem_we, mem_addr, mem_wdata.
  - Digit count and carry cleared.
  - RAM contents are don't-care because INIT rewrites them.
- mem_we is high only in INIT and WR.

## Timing
- INIT: N_TERMS cycles, mem_we=1, addr 0,1,…,N_TERMS-1, wdata=1.
- Divider latency DIV_W+1 cycles from start pulse to done pulse, where DIV_W=DATA_W+4.
- Per term: RD 1 + WT 1 + DIV (DIV_W+1) + WR 1 = DIV_W+4 cycles (16 at defaults).
- Per digit, with ready held high: 1 (PASS_START) + N_TERMS·(DIV_W+4) + 1 (OUT).
- Start to EMIT2 valid: N_TERMS+1 cycles.
- busy rises the cycle after start is sampled.
- done rises the cycle after the final handshake, and busy falls in that same cycle.

## Structure
- `spigot_e_pkg`:
  - state enum;
  - DIV_W derivation;
  - digit width constant (4);
  - constant RADIX_OFFSET=2.
- Sub-module `spigot_divider`:
  - restoring divider, one quotient bit per cycle;
  - inputs start, dividend (DIV_W), divisor (DATA_W);
  - outputs quotient (4 LSBs used), remainder (DATA_W), done pulse.
- The RAM is external to this block.

## Test plan
- Reset check: assert rst for 3 cycles mid-INIT → next cycle all outputs 0 and state IDLE; a later start completes normally.
- Digit stream: defaults, ready tied high, start → 32 digits 2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,2,3,5,3,6,0,2,8,7,4,7,1,3,5,2,6 → then done=1, busy=0.
- INIT trace: start → exactly 32 writes, addr 0..31, wdata 1, consecutive cycles; first digit valid on cycle 33.
- Backpressure: hold ready low 10 cycles on digit 3 → digit stays 1, valid stays high, no RAM activity; the stream resumes unchanged.
- Per-term timing: measure WR-to-WR spacing of mem_we → 16 cycles; per-digit gap with ready high → 514 cycles.
- Control corner cases:
  - start pulses while busy → ignored, digit stream unaltered;
  - start in DONE → restart, and the first digit is again 2;
  - rst during OUT → valid drops next cycle.

Source files
------------

// File: rtl/spigot_e_sequencer_pkg.sv
// Shared types and constants for the spigot-of-e sequencer and its divider.
package spigot_e_pkg;

    localparam int DIGIT_W      = 4;
    localparam int RADIX_OFFSET = 2;
    // Headroom above the remainder width for x = r*10 + carry.
    localparam int DIV_EXTRA_W  = 4;

    function automatic int div_width(input int data_w);
        return data_w + DIV_EXTRA_W;
    endfunction

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_EMIT2,
        S_PASS_START,
        S_RD,
        S_WT,
        S_DIV,
        S_WR,
        S_OUT,
        S_DONE
    } state_e;

endpackage

// File: rtl/spigot_e_sequencer_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses DIVIDEND_W+1 cycles after start.
module spigot_divider #(
    parameter int DIVIDEND_W = 12,
    parameter int DIVISOR_W  = 8,
    parameter int QUOT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  done
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] q_q, q_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q;
    logic [DIVISOR_W:0]    trial;
    logic                  ge;

    always_comb begin
        trial = {rem_q, q_q[DIVIDEND_W-1]};
        ge    = trial >= {1'b0, dvs_q};
        q_d   = q_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        if (start) begin
            q_d   = dividend;
            rem_d = '0;
            cnt_d = CNT_W'(DIVIDEND_W);
        end else if (cnt_q != '0) begin
            // Dividend bits shift out the top while quotient bits shift in below.
            cnt_d = cnt_q - 1'b1;
            q_d   = {q_q[DIVIDEND_W-2:0], ge};
            rem_d = ge ? DIVISOR_W'(trial - {1'b0, dvs_q}) : trial[DIVISOR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        q_q   <= q_d;
        rem_q <= rem_d;
        if (start) begin
            dvs_q <= divisor;
        end
    end

    assign quotient  = q_q[QUOT_W-1:0];
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/spigot_e_sequencer.sv
// Spigot-of-e controller: initialises the external remainder RAM, runs one mixed-radix pass per digit, streams BCD digits.
module spigot_e_sequencer
    import spigot_e_pkg::*;
#(
    parameter int N_TERMS    = 32,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int MAX_DIGITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [3:0]         digit,
    output logic               digit_valid,
    input  logic               digit_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_we,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam int DIV_W = div_width(DATA_W);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_DIGITS);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [DIGIT_W-1:0]   carry_q, carry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 div_start;
    logic [DIV_W-1:0]     rd_ext;
    logic [DIV_W-1:0]     div_dividend;
    logic [DATA_W-1:0]    div_divisor;
    logic [DIGIT_W-1:0]   div_quot;
    logic [DATA_W-1:0]    div_rem;
    logic                 div_done;

    // The divider latches x in WT, straight from the RAM read port.
    assign rd_ext       = DIV_W'(mem_rdata);
    assign div_dividend = (rd_ext << 3) + (rd_ext << 1) + DIV_W'(carry_q);
    assign div_divisor  = DATA_W'(idx_q) + DATA_W'(RADIX_OFFSET);

    spigot_divider #(
        .DIVIDEND_W (DIV_W),
        .DIVISOR_W  (DATA_W),
        .QUOT_W     (DIGIT_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .dividend   (div_dividend),
        .divisor    (div_divisor),
        .quotient   (div_quot),
        .remainder  (div_rem),
        .done       (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_INIT: begin
                if (idx_q == LAST_IDX) state_d = S_EMIT2;
                else                   idx_d   = idx_q + 1'b1;
            end
            S_EMIT2: begin
                if (digit_ready) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (LAST_CNT == CNT_W'(1)) ? S_DONE : S_PASS_START;
                end
            end
            S_PASS_START: begin
                idx_d   = LAST_IDX;
                carry_d = '0;
                state_d = S_RD;
            end
            S_RD:  state_d = S_WT;
            S_WT:  state_d = S_DIV;
            S_DIV: if (div_done) state_d = S_WR;
            S_WR: begin
                carry_d = div_quot;
                if (idx_q == '0) begin
                    state_d = S_OUT;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = S_RD;
                end
            end
            S_OUT: begin
                if (digit_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q + 1'b1 == LAST_CNT) ? S_DONE : S_PASS_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        done        = (state_q == S_DONE);
        digit_valid = (state_q == S_EMIT2) || (state_q == S_OUT);
        digit       = '0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        div_start   = (state_q == S_WT);
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = DATA_W'(1);
            end
            S_RD: mem_addr = idx_q;
            S_WR: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = div_rem;
            end
            S_EMIT2: digit = DIGIT_W'(2);
            S_OUT:   digit = carry_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spigot_e_sequencer.sv
// Bench for spigot_e_sequencer: behavioural RAM, queued expected digits checked by a handshake monitor.
`timescale 1ns/1ps
module tb_spigot_e_sequencer;

    localparam int N_TERMS    = 32;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 8;
    localparam int MAX_DIGITS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        digit;
    logic              digit_valid;
    logic              digit_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [N_TERMS];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_n  = 0;
    int exp_q[$];
    int hs_cyc[$];
    int e_digits [MAX_DIGITS] = '{2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,
                                  2,3,5,3,6,0,2,8,7,4,7,1,3,5,2,6};

    spigot_e_sequencer #(
        .N_TERMS    (N_TERMS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Digit monitor: pops one expected digit per accepted handshake.
    always @(negedge clk) begin
        if (!rst && digit_valid && digit_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_digit: got %0d expected none (cycle %0d)", digit, cyc);
            end else begin
                check("digit", digit, exp_q.pop_front());
            end
            hs_n++;
            hs_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_run();
        foreach (e_digits[k]) exp_q.push_back(e_digits[k]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digit"}, digit, 0);
        check({tag, "_valid"}, digit_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic wait_done(input int lim);
        for (int k = 0; k < lim && !done; k++) tick();
        check("wait_done", done, 1);
    endtask

    task automatic wait_valid(input int lim);
        for (int k = 0; k < lim && !digit_valid; k++) tick();
        check("wait_valid", digit_valid, 1);
    endtask

    task automatic wait_we(input int lim);
        for (int k = 0; k < lim && !mem_we; k++) tick();
        check("wait_we", mem_we, 1);
    endtask

    task automatic wait_hs(input int n, input int lim);
        for (int k = 0; k < lim && hs_n < n; k++) tick();
        check("wait_hs", int'(hs_n >= n), 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t0;
        rst = 1'b1;
        start = 1'b0;
        digit_ready = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Run 1: INIT trace, timing, full digit stream.
        push_run();
        hs_cyc.delete();
        pulse_start();
        check("start_busy", busy, 1);
        for (int k = 0; k < N_TERMS; k++) begin
            check("init_we", mem_we, 1);
            check("init_addr", mem_addr, k);
            check("init_wdata", mem_wdata, 1);
            tick();
        end
        check("emit2_valid", digit_valid, 1);
        check("emit2_digit", digit, 2);
        t0 = cyc;
        wait_we(100);
        check("first_wr_delay", cyc - t0, 17);
        check("wr31_addr", mem_addr, 31);
        check("wr31_wdata", mem_wdata, 10);
        t0 = cyc;
        tick();
        wait_we(100);
        check("wr_spacing", cyc - t0, 16);
        check("wr30_addr", mem_addr, 30);
        check("wr30_wdata", mem_wdata, 10);
        wait_done(20000);
        check("run1_busy", busy, 0);
        check("run1_left", exp_q.size(), 0);
        check("run1_hs", hs_cyc.size(), MAX_DIGITS);
        if (hs_cyc.size() == MAX_DIGITS) begin
            check("gap_first", hs_cyc[1] - hs_cyc[0], 514);
            check("gap_last", hs_cyc[31] - hs_cyc[30], 514);
            check("done_rise", cyc, hs_cyc[31] + 1);
        end

        // Run 2: restart from DONE, ignored starts, backpressure on digit 3.
        base = hs_n;
        push_run();
        pulse_start();
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);
        repeat (4) tick();
        pulse_start();
        wait_hs(base + 2, 1200);
        digit_ready = 1'b0;
        pulse_start();
        wait_valid(1000);
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", digit_valid, 1);
            check("bp_digit", digit, 1);
            check("bp_we", mem_we, 0);
            tick();
        end
        digit_ready = 1'b1;
        wait_done(20000);
        check("run2_hs", hs_n - base, MAX_DIGITS);
        check("run2_left", exp_q.size(), 0);

        // Run 3: reset in the middle of INIT, then a clean run.
        pulse_start();
        repeat (5) tick();
        rst = 1'b1;
        repeat (3) tick();
        check_zero("midinit_rst");
        rst = 1'b0;
        tick();
        base = hs_n;
        push_run();
        pulse_start();
        wait_done(20000);
        check("run3_hs", hs_n - base, MAX_DIGITS);
        check("run3_left", exp_q.size(), 0);
        check("run3_busy", busy, 0);

        // Run 4: reset while a digit is presented.
        base = hs_n;
        push_run();
        pulse_start();
        wait_hs(base + 4, 3000);
        digit_ready = 1'b0;
        wait_valid(1000);
        check("out_digit5", digit, 2);
        rst = 1'b1;
        tick();
        check("rst_out_valid", digit_valid, 0);
        check("rst_out_busy", busy, 0);
        check("rst_out_digit", digit, 0);
        rst = 1'b0;
        exp_q.delete();
        digit_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
